// File: rtl/mux_tree_pipe.sv
// mux_tree_pipe
//   Pipelined N-to-1 select tree (N = 2**SEL_W) with valid/ready flow control.
//   The select is resolved LSB-first: tree level k uses sel[k]. A register stage
//   follows every LVL_PER_STG levels, so there are ceil(SEL_W/LVL_PER_STG)
//   stages; the last stage may resolve fewer levels. A sideband tag travels
//   with each beat unchanged.
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous reset, active low
//   flush      in   synchronous; drops every in-flight beat at the next edge
//   in_valid   in   input beat valid
//   in_ready   out  block accepts a beat this cycle
//   x          in   flattened inputs, input i = x[i*WIDTH +: WIDTH]
//   sel        in   index of the input to forward
//   tag        in   sideband carried with the beat
//   out_valid  out  output beat valid
//   out_ready  in   consumer accepts the output beat
//   out_data   out  selected input value
//   out_tag    out  tag of the output beat
module mux_tree_pipe #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned SEL_W       = 5,
  parameter int unsigned LVL_PER_STG = 2,
  parameter int unsigned TAG_W       = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH*(2**SEL_W)-1:0] x,
  input  logic [SEL_W-1:0]            sel,
  input  logic [TAG_W-1:0]            tag,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WIDTH-1:0]            out_data,
  output logic [TAG_W-1:0]            out_tag
);

  localparam int unsigned S = (SEL_W + LVL_PER_STG - 1) / LVL_PER_STG;

  for (genvar k = 0; k < S; k++) begin : g_stg
    // Levels resolved before (lin) and after (lout) this stage.
    localparam int unsigned LIN  = k * LVL_PER_STG;
    localparam int unsigned LOUT = (LIN + LVL_PER_STG > SEL_W) ? SEL_W : LIN + LVL_PER_STG;
    localparam int unsigned NL   = LOUT - LIN;
    localparam int unsigned RIN  = SEL_W - LIN;
    localparam int unsigned ROUT = SEL_W - LOUT;
    localparam int unsigned NIN  = 1 << RIN;
    localparam int unsigned NOUT = 1 << ROUT;

    logic                  up_vld;
    logic [NIN*WIDTH-1:0]  up_data;
    logic [RIN-1:0]        up_sel;
    logic [TAG_W-1:0]      up_tag;
    logic                  dn_rdy;
    logic                  rdy;
    logic                  q_vld;
    logic [NOUT*WIDTH-1:0] q_data;
    logic [TAG_W-1:0]      q_tag;
    logic [NOUT*WIDTH-1:0] nxt_data;

    if (k == 0) begin : g_src
      assign up_vld  = in_valid;
      assign up_data = x;
      assign up_sel  = sel;
      assign up_tag  = tag;
    end else begin : g_src
      assign up_vld  = g_stg[k-1].q_vld;
      assign up_data = g_stg[k-1].q_data;
      assign up_sel  = g_stg[k-1].g_res.q_sel;
      assign up_tag  = g_stg[k-1].q_tag;
    end

    if (k == S - 1) begin : g_dn
      assign dn_rdy = out_ready;
    end else begin : g_dn
      assign dn_rdy = g_stg[k+1].rdy;
    end

    // An empty stage always accepts, so bubbles collapse under a stall.
    assign rdy = !q_vld || dn_rdy;

    // Each group of 2**NL adjacent words collapses to one word, picked by the
    // low NL bits of the residual select.
    always_comb begin
      nxt_data = '0;
      for (int unsigned j = 0; j < NOUT; j++) begin
        nxt_data[j*WIDTH +: WIDTH] =
          up_data[(j * (NIN / NOUT) + 32'(up_sel[NL-1:0])) * WIDTH +: WIDTH];
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        q_vld  <= 1'b0;
        q_data <= '0;
        q_tag  <= '0;
      end else begin
        if (flush) begin
          q_vld <= 1'b0;
        end else if (rdy) begin
          q_vld <= up_vld;
        end
        if (rdy) begin
          q_data <= nxt_data;
          q_tag  <= up_tag;
        end
      end
    end

    // The final stage has consumed every select bit, so it keeps no residual.
    if (ROUT > 0) begin : g_res
      logic [ROUT-1:0] q_sel;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          q_sel <= '0;
        end else if (rdy) begin
          q_sel <= up_sel[RIN-1:NL];
        end
      end
    end
  end

  assign in_ready  = g_stg[0].rdy;
  assign out_valid = g_stg[S-1].q_vld;
  assign out_data  = g_stg[S-1].q_data;
  assign out_tag   = g_stg[S-1].q_tag;

endmodule

// File: tb/tb_mux_tree_pipe.sv
// tb_mux_tree_pipe
//   Self-checking bench for mux_tree_pipe: default configuration against a
//   queue-based reference model, plus three narrow configurations checked for
//   latency and selection of every input.
module tb_mux_tree_pipe;

  localparam int unsigned W  = 32;
  localparam int unsigned SW = 5;
  localparam int unsigned TW = 4;
  localparam int unsigned N  = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [W*N-1:0]  x;
  logic [SW-1:0]   sel;
  logic [TW-1:0]   tag;
  logic [W-1:0]    out_data;
  logic [TW-1:0]   out_tag;
  logic [31:0]     xv [N];

  always_comb begin
    x = '0;
    for (int unsigned i = 0; i < N; i++) x[i*W +: W] = xv[i];
  end

  mux_tree_pipe #(.WIDTH(32), .SEL_W(5), .LVL_PER_STG(2), .TAG_W(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .sel(sel), .tag(tag), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag)
  );

  // Narrow configurations sharing one stimulus.
  logic          sw_valid;
  logic [4:0]    sw_sel5;
  logic [2:0]    sw_sel3;
  logic [3:0]    sw_tag;
  logic [255:0]  xw5;
  logic [63:0]   xw3;
  logic          a_rdy, a_valid, b_rdy, b_valid, c_rdy, c_valid;
  logic [7:0]    a_data, b_data, c_data;
  logic [3:0]    a_tag, b_tag, c_tag;

  mux_tree_pipe #(.WIDTH(8), .SEL_W(3), .LVL_PER_STG(2), .TAG_W(4)) u_a (
    .clk(clk), .rst_n(rst_n), .flush(1'b0), .in_valid(sw_valid), .in_ready(a_rdy),
    .x(xw3), .sel(sw_sel3), .tag(sw_tag), .out_valid(a_valid), .out_ready(1'b1),
    .out_data(a_data), .out_tag(a_tag)
  );
  mux_tree_pipe #(.WIDTH(8), .SEL_W(5), .LVL_PER_STG(1), .TAG_W(4)) u_b (
    .clk(clk), .rst_n(rst_n), .flush(1'b0), .in_valid(sw_valid), .in_ready(b_rdy),
    .x(xw5), .sel(sw_sel5), .tag(sw_tag), .out_valid(b_valid), .out_ready(1'b1),
    .out_data(b_data), .out_tag(b_tag)
  );
  mux_tree_pipe #(.WIDTH(8), .SEL_W(5), .LVL_PER_STG(5), .TAG_W(4)) u_c (
    .clk(clk), .rst_n(rst_n), .flush(1'b0), .in_valid(sw_valid), .in_ready(c_rdy),
    .x(xw5), .sel(sw_sel5), .tag(sw_tag), .out_valid(c_valid), .out_ready(1'b1),
    .out_data(c_data), .out_tag(c_tag)
  );

  typedef struct {
    logic [31:0] d;
    logic [3:0]  t;
    int unsigned c;
  } beat_t;

  beat_t       exp_q [$];
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned cyc     = 0;
  int unsigned nout    = 0;
  bit          acc, chk_lat, ir_s;
  logic [31:0] last_d;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", nm, got, want);
    end
  endtask

  // One clock cycle: sample transfers just before the rising edge, update the
  // reference queue, return on the following falling edge.
  task automatic tick();
    beat_t e;
    acc = 1'b0;
    #4;
    cyc++;
    ir_s = in_ready;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out", 64'(out_data), 64'hDEAD_BEEF_0000_0000);
      end else begin
        e = exp_q.pop_front();
        nout++;
        last_d = out_data;
        chk("out_data", 64'(out_data), 64'(e.d));
        chk("out_tag", 64'(out_tag), 64'(e.t));
        if (chk_lat) chk("latency", 64'(cyc - e.c), 64'd3);
      end
    end
    if (flush) begin
      exp_q.delete();
    end else if (in_valid && in_ready) begin
      exp_q.push_back('{d: xv[sel], t: tag, c: cyc});
      acc = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic default_x();
    for (int unsigned i = 0; i < N; i++) xv[i] = 32'hA000_0000 + i;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned t1_sel [4] = '{0, 31, 17, 10};
    int unsigned b, n0, la, lb, lc;
    logic [31:0] hold;

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    sel = '0; tag = '0; chk_lat = 1'b0; last_d = '0;
    sw_valid = 1'b0; sw_sel5 = '0; sw_sel3 = '0; sw_tag = '0;
    default_x();
    for (int unsigned i = 0; i < 32; i++) xw5[i*8 +: 8] = 8'(i * 37 + 11);
    for (int unsigned i = 0; i < 8; i++)  xw3[i*8 +: 8] = 8'(i * 53 + 200);

    // Reset state
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_tag", 64'(out_tag), 64'd0);
    rst_n = 1'b1;
    #1 chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);

    // 1: back-to-back beats, no stalls
    out_ready = 1'b1; chk_lat = 1'b1; n0 = nout;
    for (int unsigned i = 0; i < 4; i++) begin
      in_valid = 1'b1; sel = 5'(t1_sel[i]); tag = 4'(i + 1);
      tick();
    end
    in_valid = 1'b0;
    repeat (5) tick();
    chk("t1_count", 64'(nout - n0), 64'd4);
    chk("t1_last", 64'(last_d), 64'hA000_000A);
    chk("t1_drain", 64'(exp_q.size()), 64'd0);

    // 2: stall fills the pipe, release delivers all beats in order
    out_ready = 1'b0; chk_lat = 1'b0; b = 0; n0 = nout;
    for (int unsigned c = 0; c < 5; c++) begin
      in_valid = 1'b1; sel = 5'(b * 5 + 1); tag = 4'(b);
      tick();
      if (acc) b++;
    end
    chk("t2_held", 64'(b), 64'd3);
    chk("t2_in_ready_full", 64'(ir_s), 64'd0);
    chk("t2_out_valid", 64'(out_valid), 64'd1);
    hold = out_data;
    tick();
    chk("t2_stable", 64'(out_data), 64'(hold));
    chk("t2_head", 64'(out_data), 64'(exp_q[0].d));
    out_ready = 1'b1;
    for (int unsigned c = 0; c < 40 && b < 6; c++) begin
      in_valid = 1'b1; sel = 5'(b * 5 + 1); tag = 4'(b);
      tick();
      if (acc) b++;
    end
    in_valid = 1'b0;
    repeat (5) tick();
    chk("t2_count", 64'(nout - n0), 64'd6);
    chk("t2_drain", 64'(exp_q.size()), 64'd0);

    // 3: alternating valid, random back-pressure and data
    b = 0;
    for (int unsigned c = 0; c < 4000 && b < 200; c++) begin
      in_valid = (c % 2 == 0);
      sel = 5'($urandom); tag = 4'($urandom);
      for (int unsigned i = 0; i < N; i++) xv[i] = $urandom;
      out_ready = 1'($urandom_range(0, 1));
      tick();
      if (acc) b++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (5) tick();
    chk("t3_accepted", 64'(b), 64'd200);
    chk("t3_drain", 64'(exp_q.size()), 64'd0);

    // 4: flush
    default_x();
    flush = 1'b1; in_valid = 1'b1; sel = 5'd3; tag = 4'h3;
    tick();
    chk("t4_ir_flush_empty", 64'(ir_s), 64'd1);
    flush = 1'b0; in_valid = 1'b0;
    repeat (4) tick();
    chk("t4_discarded", 64'(out_valid), 64'd0);
    out_ready = 1'b0; b = 0;
    for (int unsigned c = 0; c < 8 && b < 3; c++) begin
      in_valid = 1'b1; sel = 5'(b + 20); tag = 4'(b + 4);
      tick();
      if (acc) b++;
    end
    chk("t4_filled", 64'(b), 64'd3);
    flush = 1'b1; in_valid = 1'b1; sel = 5'd2; tag = 4'h2;
    tick();
    chk("t4_ir_flush_full", 64'(ir_s), 64'd0);
    flush = 1'b0; in_valid = 1'b0;
    chk("t4_out_valid_after_flush", 64'(out_valid), 64'd0);
    out_ready = 1'b1; chk_lat = 1'b1;
    in_valid = 1'b1; sel = 5'd5; tag = 4'hC;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    chk("t4_sel5_data", 64'(last_d), 64'hA000_0005);
    chk("t4_drain", 64'(exp_q.size()), 64'd0);

    // 5: asynchronous reset mid-stream
    chk_lat = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      in_valid = 1'b1; sel = 5'(i * 7 + 3); tag = 4'(i + 8);
      tick();
    end
    chk("t5_busy", 64'(out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", 64'(out_valid), 64'd0);
    chk("t5_rst_data", 64'(out_data), 64'd0);
    chk("t5_rst_tag", 64'(out_tag), 64'd0);
    exp_q.delete(); in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int unsigned i = 0; i < 6; i++) begin
      tick();
      chk("t5_no_stale", 64'(out_valid), 64'd0);
    end
    chk_lat = 1'b1;
    in_valid = 1'b1; sel = 5'd9; tag = 4'h9;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    chk("t5_after_data", 64'(last_d), 64'hA000_0009);
    chk("t5_drain", 64'(exp_q.size()), 64'd0);

    // 6: narrow configurations, every input, latency 2 / 5 / 1
    for (int unsigned s = 0; s < 32; s++) begin
      sw_sel5 = 5'(s); sw_sel3 = 3'(s % 8); sw_tag = 4'(s); sw_valid = 1'b1;
      @(negedge clk);
      sw_valid = 1'b0;
      la = 0; lb = 0; lc = 0;
      for (int unsigned cc = 1; cc <= 7; cc++) begin
        if (a_valid) begin
          if (la != 0) chk("sw_a_dup", 64'(cc), 64'(la));
          else begin
            la = cc;
            chk("sw_a_data", 64'(a_data), 64'(8'((s % 8) * 53 + 200)));
            chk("sw_a_tag", 64'(a_tag), 64'(4'(s)));
          end
        end
        if (b_valid) begin
          if (lb != 0) chk("sw_b_dup", 64'(cc), 64'(lb));
          else begin
            lb = cc;
            chk("sw_b_data", 64'(b_data), 64'(8'(s * 37 + 11)));
            chk("sw_b_tag", 64'(b_tag), 64'(4'(s)));
          end
        end
        if (c_valid) begin
          if (lc != 0) chk("sw_c_dup", 64'(cc), 64'(lc));
          else begin
            lc = cc;
            chk("sw_c_data", 64'(c_data), 64'(8'(s * 37 + 11)));
          end
        end
        @(negedge clk);
      end
      chk("sw_a_lat", 64'(la), 64'd2);
      chk("sw_b_lat", 64'(lb), 64'd5);
      chk("sw_c_lat", 64'(lc), 64'd1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
